// File: rtl/somador_pkg.sv
// -----------------------------------------------------------------------------
// somador_pkg
// Shared definitions for the pipelined adder/subtractor of the RPN ALU:
//   FLAG_*        bit positions of N/Z/C/V when the flags are packed into a nibble
//   MODE_*        encoding of the Sub input
//   slice_legal   elaboration-time legality check for WIDTH/STAGES
//   slice_width   bits per pipeline slice (WIDTH/STAGES), 0 when illegal
// -----------------------------------------------------------------------------
package somador_pkg;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit slice_legal(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic int slice_width(input int width, input int stages);
    return slice_legal(width, stages) ? (width / stages) : 0;
  endfunction

endpackage

// File: rtl/somador_fatia.sv
// -----------------------------------------------------------------------------
// somador_fatia
// One registered slice of the carry chain: adds a CW-bit chunk of A and B'
// plus the incoming carry, and registers the carry-out and the stage valid.
// The chunk sum is combinational; the parent delays it to line up with the
// upper chunks.
//   clk, rst_n    clock / asynchronous active-low reset
//   en            pipeline advance (all stages move together)
//   valid_in      valid of the operation entering this slice
//   a, b, cin     operand chunks (b already inverted for SUB) and carry in
//   sum           combinational chunk sum
//   carry         registered carry-out (held across bubbles)
//   valid         registered stage valid
// -----------------------------------------------------------------------------
module somador_fatia
  import somador_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          valid_in,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          carry,
  output logic          valid
);

  logic [CW:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign sum   = total[CW-1:0];

  // NOTE: non-blocking assignments for every flop, so all slices sample the
  // pre-edge values of their neighbours regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      carry <= 1'b0;
    end else if (en) begin
      valid <= valid_in;
      // Bubbles leave the carry alone; in the last slice this register is Co,
      // which must keep the last valid result.
      if (valid_in) carry <= total[CW];
    end
  end

endmodule

// File: rtl/somador_pipeline.sv
// -----------------------------------------------------------------------------
// somador_pipeline
// Pipelined WIDTH-bit adder/subtractor with NZCV flags and a valid/ready
// handshake. The carry chain is cut into STAGES slices; operand chunks are
// skewed to meet their carry and finished sum chunks are deskewed so the whole
// result leaves in one cycle. Latency STAGES, throughput one result per cycle.
//   clk, rst_n           clock / asynchronous active-low reset
//   in_valid, in_ready   operand handshake (A, B, Cin, Sub)
//   A, B                 operands
//   Cin                  carry in, ADD only
//   Sub                  MODE_ADD: S=A+B+Cin, MODE_SUB: S=A-B
//   out_valid, out_ready result handshake
//   S, Co, V, Z, N       result, carry-out (SUB: 1 = no borrow), overflow,
//                        zero, negative
// -----------------------------------------------------------------------------
module somador_pipeline
  import somador_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int CW = slice_width(WIDTH, STAGES);

  if (!slice_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("somador_pipeline: WIDTH must be >= 2 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [STAGES:0]  v;       // v[s]: valid of the operation sitting at boundary s
  logic [STAGES-1:0] carry;  // registered carry-out of each slice
  logic [WIDTH-1:0] s_next;  // full sum about to be loaded into S
  logic             a_msb;
  logic             b_msb;
  logic             n_q;
  logic             z_q;
  logic             v_q;

  // Single global stall: nothing moves while a result is refused.
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;

  // Mode is resolved once at the input; slices only ever add.
  assign b_eff     = (Sub == MODE_SUB) ? ~B : B;
  assign cin_eff   = (Sub == MODE_SUB) ? 1'b1 : Cin;

  assign v[0]      = in_valid;
  assign out_valid = v[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [CW-1:0] a_at;
    logic [CW-1:0] b_at;
    logic          cin_at;
    logic [CW-1:0] sum;
    // Deskew line: chunk k needs STAGES-k registers, the last one being its
    // share of the S output register.
    logic [(STAGES-k)*CW-1:0] s_q;

    if (k == 0) begin : g_direct
      assign a_at   = A[CW-1:0];
      assign b_at   = b_eff[CW-1:0];
      assign cin_at = cin_eff;
    end else begin : g_skew
      // Skew line: chunk k waits k cycles for the carry from slice k-1.
      logic [k*CW-1:0] a_q;
      logic [k*CW-1:0] b_q;

      // NOTE: pure data registers do not strictly need a reset, but clearing
      // them keeps simulation X-free and costs nothing on an async-reset flop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          if (adv && v[0]) begin
            a_q[CW-1:0] <= A[k*CW +: CW];
            b_q[CW-1:0] <= b_eff[k*CW +: CW];
          end
          for (int i = 2; i <= k; i++) begin
            if (adv && v[i-1]) begin
              a_q[(i-1)*CW +: CW] <= a_q[(i-2)*CW +: CW];
              b_q[(i-1)*CW +: CW] <= b_q[(i-2)*CW +: CW];
            end
          end
        end
      end

      assign a_at   = a_q[(k-1)*CW +: CW];
      assign b_at   = b_q[(k-1)*CW +: CW];
      assign cin_at = carry[k-1];
    end

    somador_fatia #(.CW(CW)) u_fatia (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .valid_in (v[k]),
      .a        (a_at),
      .b        (b_at),
      .cin      (cin_at),
      .sum      (sum),
      .carry    (carry[k]),
      .valid    (v[k+1])
    );

    // Each deskew register loads only when a valid op moves into it, so S
    // keeps its last result while bubbles pass through.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
      end else begin
        if (adv && v[k]) s_q[CW-1:0] <= sum;
        for (int i = 2; i <= STAGES - k; i++) begin
          if (adv && v[k+i-1]) s_q[(i-1)*CW +: CW] <= s_q[(i-2)*CW +: CW];
        end
      end
    end

    assign S[k*CW +: CW] = s_q[(STAGES-k-1)*CW +: CW];

    if (k == STAGES - 1) begin : g_msb
      assign s_next[k*CW +: CW] = sum;
      assign a_msb = a_at[CW-1];
      assign b_msb = b_at[CW-1];
    end else begin : g_low
      assign s_next[k*CW +: CW] = s_q[(STAGES-k-2)*CW +: CW];
    end
  end

  // Flags are formed from the sum entering the output register. V uses the
  // sign form (equal operand signs, different result sign), which equals
  // carry-into-MSB xor carry-out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else if (adv && v[STAGES-1]) begin
      n_q <= s_next[WIDTH-1];
      z_q <= ~|s_next;
      v_q <= (a_msb == b_msb) && (s_next[WIDTH-1] != a_msb);
    end
  end

  assign Co = carry[STAGES-1];
  assign V  = v_q;
  assign Z  = z_q;
  assign N  = n_q;

endmodule

// File: tb/tb_somador_pipeline.sv
// -----------------------------------------------------------------------------
// tb_somador_pipeline
// Scoreboard bench: operands accepted by the DUT push an expected result
// (from a signed/unsigned arithmetic model or a directed constant) into a
// queue; monitors pop and compare whenever a result is presented. Covers the
// default 8/2 instance plus 16/4 and 16/1 instances.
// -----------------------------------------------------------------------------
module tb_somador_pipeline;
  import somador_pkg::*;

  typedef struct {
    logic [15:0] s;
    logic        co, v, z, n;
    int          cyc;
    int          stl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;

  // 8-bit, 2-stage instance
  logic       in_valid, in_ready, out_valid, out_ready, cin, sub, co, vf, zf, nf;
  logic [7:0] a, b, s;

  // 16-bit instances (4 stages and 1 stage) share their inputs
  logic        w_valid, w_cin, w_sub, w_oready;
  logic [15:0] wa, wb;
  logic        w4_ready, w4_valid, w4_co, w4_v, w4_z, w4_n;
  logic        w1_ready, w1_valid, w1_co, w1_v, w1_z, w1_n;
  logic [15:0] w4_s, w1_s;

  somador_pipeline #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Co(co), .V(vf), .Z(zf), .N(nf)
  );

  somador_pipeline #(.WIDTH(16), .STAGES(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w4_ready),
    .A(wa), .B(wb), .Cin(w_cin), .Sub(w_sub), .out_valid(w4_valid), .out_ready(w_oready),
    .S(w4_s), .Co(w4_co), .V(w4_v), .Z(w4_z), .N(w4_n)
  );

  somador_pipeline #(.WIDTH(16), .STAGES(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w1_ready),
    .A(wa), .B(wb), .Cin(w_cin), .Sub(w_sub), .out_valid(w1_valid), .out_ready(w_oready),
    .S(w1_s), .Co(w1_co), .V(w1_v), .Z(w1_z), .N(w1_n)
  );

  int   tests = 0;
  int   fails = 0;
  int   stall_cnt = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t q1[$];
  exp_t last8;
  exp_t dir_exp, w_dir_exp;
  logic dir_use, w_dir_use;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] rs, input logic rco, input logic rv,
                              input logic rz, input logic rn);
    exp_t e;
    e.s = rs; e.co = rco; e.v = rv; e.z = rz; e.n = rn; e.cyc = 0; e.stl = 0;
    return e;
  endfunction

  // Reference: unsigned result modulo 2^width, Co from unsigned range / A>=B,
  // V from the exact signed result falling outside the representable range.
  function automatic exp_t model(input int width, input longint ia, input longint ib,
                                 input logic icin, input logic isub);
    exp_t   e;
    longint m, half, sa, sb, full, sres;
    m    = longint'(1) << width;
    half = m / 2;
    sa   = (ia >= half) ? ia - m : ia;
    sb   = (ib >= half) ? ib - m : ib;
    if (isub) begin
      full = ia - ib;
      sres = sa - sb;
      e.co = (ia >= ib);
    end else begin
      full = ia + ib + longint'(icin);
      sres = sa + sb + longint'(icin);
      e.co = (full >= m);
    end
    full  = ((full % m) + m) % m;
    e.s   = 16'(full);
    e.z   = (full == 0);
    e.n   = (full >= half);
    e.v   = (sres < -half) || (sres >= half);
    e.cyc = 0;
    e.stl = 0;
    return e;
  endfunction

  task automatic check_result(input string tag, input logic [15:0] rs, input logic rco,
                              input logic rv, input logic rz, input logic rn, input exp_t e);
    logic [3:0] fa, fe;
    fa[FLAG_N] = rn;  fa[FLAG_Z] = rz;  fa[FLAG_C] = rco;  fa[FLAG_V] = rv;
    fe[FLAG_N] = e.n; fe[FLAG_Z] = e.z; fe[FLAG_C] = e.co; fe[FLAG_V] = e.v;
    check({tag, "_S"}, 32'(rs), 32'(e.s));
    check({tag, "_NZCV"}, 32'(fa), 32'(fe));
  endtask

  // Monitor for the 8-bit instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (q8.size() == 0) begin
            check("main_spurious_valid", 32'(out_valid), 32'd0);
          end else begin
            check_result("main", {8'h00, s}, co, vf, zf, nf, q8[0]);
            if (out_ready) begin
              e = q8.pop_front();
              check("main_latency", 32'(cyc - e.cyc), 32'(2 + stall_cnt - e.stl));
              last8 = e;
            end else begin
              stall_cnt++;
              check("main_in_ready_stall", 32'(in_ready), 32'd0);
            end
          end
        end else begin
          check_result("main_hold", {8'h00, s}, co, vf, zf, nf, last8);
        end
        if (in_valid && in_ready) begin
          e = dir_use ? dir_exp : model(8, longint'(a), longint'(b), cin, sub);
          e.cyc = cyc;
          e.stl = stall_cnt;
          q8.push_back(e);
        end
      end
    end
  end

  // Monitor for the 16-bit instances (out_ready is always 1 there)
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (w4_valid) begin
          if (q4.size() == 0) check("w4_spurious_valid", 32'(w4_valid), 32'd0);
          else begin
            e = q4.pop_front();
            check_result("w4", w4_s, w4_co, w4_v, w4_z, w4_n, e);
            check("w4_latency", 32'(cyc - e.cyc), 32'd4);
          end
        end
        if (w1_valid) begin
          if (q1.size() == 0) check("w1_spurious_valid", 32'(w1_valid), 32'd0);
          else begin
            e = q1.pop_front();
            check_result("w1", w1_s, w1_co, w1_v, w1_z, w1_n, e);
            check("w1_latency", 32'(cyc - e.cyc), 32'd1);
          end
        end
        if (w_valid) begin
          check("w4_in_ready", 32'(w4_ready), 32'd1);
          check("w1_in_ready", 32'(w1_ready), 32'd1);
          e = w_dir_use ? w_dir_exp : model(16, longint'(wa), longint'(wb), w_cin, w_sub);
          e.cyc = cyc;
          e.stl = 0;
          if (w4_ready) q4.push_back(e);
          if (w1_ready) q1.push_back(e);
        end
      end
    end
  end

  // Present one op and hold it until accepted; returns at posedge+1 with
  // in_valid still high so ops can go back-to-back.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic isub);
    bit done;
    done = 0;
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("issue_accepted", 32'(in_ready), 32'd1);
  endtask

  task automatic issue_dir(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                           input logic isub, input logic [7:0] rs, input logic rco,
                           input logic rv, input logic rz, input logic rn);
    dir_exp = mk({8'h00, rs}, rco, rv, rz, rn);
    dir_use = 1'b1;
    issue(ia, ib, icin, isub);
    dir_use = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic w_send(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic isub, input logic use_dir, input exp_t ex);
    wa = ia; wb = ib; w_cin = icin; w_sub = isub; w_valid = 1'b1;
    w_dir_use = use_dir; w_dir_exp = ex;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = MODE_ADD;
    out_ready = 1'b1; dir_use = 1'b0; dir_exp = mk(16'h0, 0, 0, 0, 0);
    w_valid = 1'b0; wa = '0; wb = '0; w_cin = 1'b0; w_sub = MODE_ADD; w_oready = 1'b1;
    w_dir_use = 1'b0; w_dir_exp = mk(16'h0, 0, 0, 0, 0);
    last8 = mk(16'h0, 0, 0, 0, 0);

    // Reset state
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check_result("reset", {8'h00, s}, co, vf, zf, nf, mk(16'h0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed ADD/SUB vectors, back-to-back
    issue_dir(8'd200, 8'd100, 1'b0, MODE_ADD, 8'd44,  1, 0, 0, 0);
    issue_dir(8'd100, 8'd50,  1'b0, MODE_ADD, 8'd150, 0, 1, 0, 1);
    issue_dir(8'd127, 8'd0,   1'b1, MODE_ADD, 8'd128, 0, 1, 0, 1);
    issue_dir(8'd5,   8'd5,   1'b0, MODE_SUB, 8'd0,   1, 0, 1, 0);
    issue_dir(8'd3,   8'd5,   1'b0, MODE_SUB, 8'd254, 0, 0, 0, 1);
    issue_dir(8'd128, 8'd1,   1'b0, MODE_SUB, 8'd127, 1, 1, 0, 0);
    issue_dir(8'd10,  8'd3,   1'b1, MODE_SUB, 8'd7,   1, 0, 0, 0);
    issue_dir(8'd255, 8'd0,   1'b1, MODE_ADD, 8'd0,   1, 0, 1, 0);
    idle(4);

    // Backpressure: 4 ops streamed while the consumer refuses for 3 cycles
    fork
      begin
        for (int i = 0; i < 4; i++) issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);

    // Random traffic with random backpressure; inputs change every cycle
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 4) != 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(8);
    check("main_drained", 32'(q8.size()), 32'd0);

    // Reset with two ops in flight: nothing may emerge afterwards
    issue(8'd11, 8'd22, 1'b0, MODE_ADD);
    issue(8'd33, 8'd44, 1'b0, MODE_ADD);
    in_valid = 1'b0;
    check("midreset_inflight", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    q8.delete();
    last8 = mk(16'h0, 0, 0, 0, 0);
    #1 check("midreset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(6);

    // 16-bit instances: wrap-around corner, then back-to-back random ops
    w_send(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 1'b1, mk(16'h0000, 1, 0, 1, 0));
    w_send(16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 1'b1, mk(16'h8000, 0, 1, 0, 1));
    w_send(16'h1234, 16'h1234, 1'b1, MODE_SUB, 1'b1, mk(16'h0000, 1, 0, 1, 0));
    for (int i = 0; i < 12; i++)
      w_send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, w_dir_exp);
    w_valid = 1'b0;
    w_dir_use = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("w4_drained", 32'(q4.size()), 32'd0);
    check("w1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

endmodule
